mstq_arbiter: RTL

- Shares the single 18-bit bus-master command FIFO between two TLP command producers: the PHY#1 and PHY#2 receivers.
- Arbitrates round-robin at command granularity and never interleaves the words of two commands.
- Has a one-word registered output stage and a watchdog that reclaims a stalled grant.
- Sits between the receivers' mst_din/mst_wr_en/mst_full ports and the write side of the master FIFO, in the clk_125 domain.

---
 rtl/mstq_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mstq_arbiter.sv
// Round-robin arbiter sharing the bus-master command FIFO between two TLP
// producers. Optional statistics outputs are enabled by `define MSTQ_ARB_STATS_EN.

module mstq_port (
  input  logic own,
  input  logic room,
  input  logic wr_en,
  output logic full,
  output logic acc
);
  assign full = ~(own & room);
  assign acc  = wr_en & ~full;
endmodule

module mstq_arbiter #(
  parameter int TMO_W = 10,
  parameter int FIRST = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [17:0] din0,
  input  logic [17:0] din1,
  input  logic        wr_en0,
  input  logic        wr_en1,
  output logic        full0,
  output logic        full1,
  output logic [17:0] mst_din,
  output logic        mst_wr_en,
  input  logic        mst_full,
  output logic [1:0]  grant,
  output logic [2:0]  err,
  input  logic        err_clr
`ifdef MSTQ_ARB_STATS_EN
  ,
  output logic [15:0] cmd_cnt0,
  output logic [15:0] cmd_cnt1,
  output logic [15:0] wait_max
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic             LAST_RST = (FIRST == 0);
  localparam logic [TMO_W-1:0] WD_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state, nxt;
  logic             last_win;
  logic             first_word;
  logic [TMO_W-1:0] wd_cnt;
  logic             out_valid;
  logic [17:0]      out_data;

  logic [1:0]       req_v, wr_v, own_v, full_v, acc_v;
  logic [1:0][17:0] din_v;
  logic             room, acc, cur;
  logic [17:0]      word;
  logic             sop, eop;
  logic             idle_tick, wd_fire, grant_end;
  logic [2:0]       err_set;

  assign req_v = {req1, req0};
  assign wr_v  = {wr_en1, wr_en0};
  assign din_v = {din1, din0};
  assign own_v = {state == OWN1, state == OWN0};

  // Room exists when the output stage is empty or drains this same cycle.
  assign room = ~out_valid | ~mst_full;

  mstq_port u_port [1:0] (
    .own   (own_v),
    .room  ({2{room}}),
    .wr_en (wr_v),
    .full  (full_v),
    .acc   (acc_v)
  );

  assign acc  = |acc_v;
  assign cur  = (state == OWN1);
  assign word = acc_v[1] ? din_v[1] : din_v[0];
  assign sop  = word[17];
  assign eop  = word[16];

  // Fires on the last of 2^TMO_W-1 idle granted cycles so the grant drops right after it.
  assign idle_tick = (state != IDLE) & ~acc & ~mst_full;
  assign wd_fire   = idle_tick & (wd_cnt == WD_LAST);
  assign grant_end = (state != IDLE) & ((acc & eop) | wd_fire);

  assign err_set = {wd_fire, acc & ~first_word & sop, acc & first_word & ~sop};

  // FSM: state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= nxt;
  end

  // FSM: next state
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (req_v[0] & req_v[1]) nxt = last_win ? OWN0 : OWN1;
        else if (req_v[0])       nxt = OWN0;
        else if (req_v[1])       nxt = OWN1;
      end
      OWN0, OWN1: if (grant_end) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    grant     = own_v;
    full0     = full_v[0];
    full1     = full_v[1];
    mst_wr_en = out_valid & ~mst_full;
    mst_din   = out_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_win   <= LAST_RST;
      first_word <= 1'b1;
      wd_cnt     <= '0;
    end else begin
      if (grant_end) last_win <= cur;
      if (state == IDLE) first_word <= 1'b1;
      else if (acc)      first_word <= 1'b0;
      if ((state == IDLE) | acc | wd_fire) wd_cnt <= '0;
      else if (idle_tick)                  wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= word;
    end else if (mst_wr_en) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   err <= '0;
    else if (err_clr) err <= '0;
    else              err <= err | err_set;
  end

`ifdef MSTQ_ARB_STATS_EN
  logic [1:0][15:0] wait_run, wait_nxt;
  logic [15:0]      wait_hi;

  always_comb begin
    wait_nxt = '0;
    for (int i = 0; i < 2; i++) begin
      if (req_v[i] & ~own_v[i])
        wait_nxt[i] = (wait_run[i] == 16'hFFFF) ? wait_run[i] : wait_run[i] + 16'd1;
    end
    wait_hi = (wait_nxt[1] > wait_nxt[0]) ? wait_nxt[1] : wait_nxt[0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_cnt0 <= '0;
      cmd_cnt1 <= '0;
      wait_max <= '0;
      wait_run <= '0;
    end else if (err_clr) begin
      cmd_cnt0 <= '0;
      cmd_cnt1 <= '0;
      wait_max <= '0;
      wait_run <= '0;
    end else begin
      if (acc_v[0] & eop) cmd_cnt0 <= cmd_cnt0 + 16'd1;
      if (acc_v[1] & eop) cmd_cnt1 <= cmd_cnt1 + 16'd1;
      wait_run <= wait_nxt;
      if (wait_hi > wait_max) wait_max <= wait_hi;
    end
  end
`endif

endmodule
